pipeline_stall_controller: RTL and testbench

Sequential stall/flush sequencer for the five-stage pipeline. It consumes the hazard verdicts produced by the bypass logic (`memstall`), the X-stage branch outcome and the multdiv unit's handshake. It generates the per-stage latch enables, bubble/flush controls and the multdiv start pulses. It owns the multdiv issue FSM, a watchdog timeout and a stall-cycle performance counter.

---
 rtl/pipeline_stall_controller.sv | 130 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Stall/flush sequencer for the five-stage pipeline. Turns the load-use
//   hazard, the X-stage branch outcome and the multdiv handshake into
//   per-stage latch enables, bubble/flush controls and multdiv start pulses.
//   It owns the multdiv issue FSM (IDLE/WAIT), a watchdog that releases a
//   stuck multdiv wait, and a saturating stall-cycle counter.
//
// Ports
//   clock, reset            : clock, async active-low reset
//   memstall                : load-use hazard (XM load feeds DX operand)
//   X_flush                 : taken branch/jump resolved in X this cycle
//   DX_mult, DX_div         : DX holds a mult / div
//   md_ready                : multdiv result valid
//   PC_we..MW_we            : latch enables
//   FD_flush, DX_bubble     : nop-insert controls for a taken branch
//   XM_bubble               : nop into XM while the front end is frozen
//   md_ctrlMULT, md_ctrlDIV : one-cycle multdiv start pulses
//   md_busy, md_timeout     : FSM in WAIT / watchdog release pulse
//   stall_cycles            : saturating count of cycles with PC_we=0
module pipeline_stall_controller #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memstall,
  input  logic        X_flush,
  input  logic        DX_mult,
  input  logic        DX_div,
  input  logic        md_ready,
  output logic        PC_we,
  output logic        FD_we,
  output logic        DX_we,
  output logic        XM_we,
  output logic        MW_we,
  output logic        FD_flush,
  output logic        DX_bubble,
  output logic        XM_bubble,
  output logic        md_ctrlMULT,
  output logic        md_ctrlDIV,
  output logic        md_busy,
  output logic        md_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} md_state_e;

  localparam logic [5:0] CNT_LAST = 6'(MD_TIMEOUT - 1);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic in_wait, at_limit, start, release_c, mdstall, any_stall;

  assign in_wait   = (state_q == WAIT);
  assign at_limit  = (cnt_q == CNT_LAST);
  // A start is held off while a load-use hazard is pending: the operands
  // in DX are not valid yet.
  assign start     = !in_wait && (DX_mult || DX_div) && !memstall;
  assign release_c = in_wait && (md_ready || at_limit);
  assign mdstall   = start || (in_wait && !release_c);
  assign any_stall = mdstall || memstall;

  always_comb begin
    PC_we     = 1'b1;
    FD_we     = 1'b1;
    DX_we     = 1'b1;
    XM_we     = 1'b1;
    MW_we     = 1'b1;
    FD_flush  = 1'b0;
    DX_bubble = 1'b0;
    XM_bubble = 1'b0;
    if (any_stall) begin
      // Freeze the front end, drain a nop into XM, let MW retire.
      PC_we     = 1'b0;
      FD_we     = 1'b0;
      DX_we     = 1'b0;
      XM_bubble = 1'b1;
    end else if (X_flush) begin
      // Branch is only honoured when nothing stalls; a stalled branch
      // stays in DX and re-resolves.
      FD_flush  = 1'b1;
      DX_bubble = 1'b1;
    end
  end

  assign md_ctrlMULT = start && DX_mult;
  assign md_ctrlDIV  = start && DX_div;
  assign md_busy     = in_wait;
  // md_ready beats the watchdog when both land in the same cycle.
  assign md_timeout  = in_wait && !md_ready && at_limit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!in_wait) begin
      if (start) begin
        state_d = WAIT;
        cnt_d   = 6'd0;
      end
    end else begin
      cnt_d = cnt_q + 6'd1;
      if (release_c) begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!PC_we && (stall_cycles_q != 16'hFFFF))
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= 6'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic memstall = 1'b0, X_flush = 1'b0, DX_mult = 1'b0, DX_div = 1'b0, md_ready = 1'b0;
  logic PC_we, FD_we, DX_we, XM_we, MW_we, FD_flush, DX_bubble, XM_bubble;
  logic md_ctrlMULT, md_ctrlDIV, md_busy, md_timeout;
  logic [15:0] stall_cycles;

  pipeline_stall_controller #(.MD_TIMEOUT(40)) dut (
    .clock(clock), .reset(reset), .memstall(memstall), .X_flush(X_flush),
    .DX_mult(DX_mult), .DX_div(DX_div), .md_ready(md_ready),
    .PC_we(PC_we), .FD_we(FD_we), .DX_we(DX_we), .XM_we(XM_we), .MW_we(MW_we),
    .FD_flush(FD_flush), .DX_bubble(DX_bubble), .XM_bubble(XM_bubble),
    .md_ctrlMULT(md_ctrlMULT), .md_ctrlDIV(md_ctrlDIV), .md_busy(md_busy),
    .md_timeout(md_timeout), .stall_cycles(stall_cycles));

  always #5 clock = ~clock;

  // {PC,FD,DX,XM,MW we, FD_flush, DX_bubble, XM_bubble, MULT, DIV, busy, timeout}
  localparam logic [11:0] RUN  = 12'b11111_000_0000;
  localparam logic [11:0] FLS  = 12'b11111_110_0000;
  localparam logic [11:0] STL  = 12'b00011_001_0000;
  localparam logic [11:0] STM  = 12'b00011_001_1000;
  localparam logic [11:0] STD  = 12'b00011_001_0100;
  localparam logic [11:0] WST  = 12'b00011_001_0010;
  localparam logic [11:0] REL  = 12'b11111_000_0010;
  localparam logic [11:0] RELT = 12'b11111_000_0011;

  typedef struct {
    logic [11:0] o;
    logic [15:0] sc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] sc_exp = 16'd0;
  string       phase = "reset";

  // Apply one cycle of stimulus at the falling edge and queue its expectation.
  task automatic step(input logic rs, ms, xf, mu, dv, rdy, input logic [11:0] exp_o);
    exp_t e;
    @(negedge clock);
    reset = rs; memstall = ms; X_flush = xf; DX_mult = mu; DX_div = dv; md_ready = rdy;
    if (!rs) sc_exp = 16'd0;
    e.o = exp_o; e.sc = sc_exp; e.tag = phase;
    sb.push_back(e);
    if (!exp_o[11] && sc_exp != 16'hFFFF) sc_exp = sc_exp + 16'd1;
  endtask

  task automatic idle(input int n, input logic [11:0] exp_o);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, exp_o);
  endtask

  // Monitor: compare mid-cycle, away from the rising edge.
  always @(negedge clock) begin
    exp_t e;
    logic [11:0] got;
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      got = {PC_we, FD_we, DX_we, XM_we, MW_we, FD_flush, DX_bubble, XM_bubble,
             md_ctrlMULT, md_ctrlDIV, md_busy, md_timeout};
      tests++;
      if (got !== e.o || stall_cycles !== e.sc) begin
        fails++;
        if (fails <= 40)
          $display("FAIL %s: outputs=%b stall_cycles=%0d, expected outputs=%b stall_cycles=%0d",
                   e.tag, got, stall_cycles, e.o, e.sc);
      end
    end
  end

  initial begin
    // Reset held, all inputs low.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, RUN);
    phase = "post_reset";
    idle(5, RUN);

    // Mult, md_ready 4 cycles after start.
    phase = "mult_ready";
    step(1, 0, 0, 1, 0, 0, STM);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, WST);
    step(1, 0, 0, 1, 0, 1, REL);
    idle(2, RUN);                       // stall_cycles reads 4 here

    // Div with no md_ready: watchdog after 40 cycles.
    phase = "div_timeout";
    step(1, 0, 0, 0, 1, 0, STD);
    for (int i = 0; i < 39; i++) step(1, 0, 0, 0, 1, 0, WST);
    step(1, 0, 0, 0, 1, 0, RELT);
    idle(2, RUN);

    // md_ready on the watchdog cycle wins: no timeout pulse.
    phase = "ready_at_limit";
    step(1, 0, 0, 0, 1, 0, STD);
    for (int i = 0; i < 39; i++) step(1, 0, 0, 0, 1, 0, WST);
    step(1, 0, 0, 0, 1, 1, REL);
    // Back-to-back: next op starts the cycle after release.
    phase = "back_to_back";
    step(1, 0, 0, 1, 0, 0, STM);
    step(1, 0, 0, 1, 0, 1, REL);
    idle(1, RUN);

    // Start deferred by memstall.
    phase = "memstall_defer";
    step(1, 1, 0, 1, 0, 0, STL);
    step(1, 1, 0, 1, 0, 0, STL);
    step(1, 0, 0, 1, 0, 0, STM);
    step(1, 0, 0, 1, 0, 1, REL);
    idle(1, RUN);

    // md_ready while idle is ignored.
    phase = "ready_idle";
    step(1, 0, 0, 0, 0, 1, RUN);

    // Flush and its gating by stalls.
    phase = "flush";
    step(1, 0, 1, 0, 0, 0, FLS);
    phase = "flush_memstall";
    step(1, 1, 1, 0, 0, 0, STL);
    phase = "flush_start";
    step(1, 0, 1, 1, 0, 0, STM);
    phase = "flush_wait";
    step(1, 0, 1, 1, 0, 0, WST);
    step(1, 0, 0, 1, 0, 1, REL);
    idle(1, RUN);

    // Reset in the middle of a wait.
    phase = "reset_mid_wait";
    step(1, 0, 0, 0, 1, 0, STD);
    step(1, 0, 0, 0, 1, 0, WST);
    step(1, 0, 0, 0, 1, 0, WST);
    step(0, 0, 0, 0, 0, 0, RUN);
    step(0, 0, 0, 0, 0, 0, RUN);
    phase = "after_reset_no_timeout";
    idle(45, RUN);

    // Counter saturation.
    phase = "saturate";
    for (int i = 0; i < 70000; i++) step(1, 1, 0, 0, 0, 0, STL);
    phase = "saturated_hold";
    idle(2, RUN);

    @(negedge clock);
    @(negedge clock);
    #4;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
